// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle main controller and the datapath / memories.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] Opcode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       ifetch_req;
  logic       ir_load;
  logic       pc_write;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       Jump;
  logic       Jalr;
  logic       Branch;
  logic [1:0] ALUOp;

  modport master (
    input  Opcode, imem_ready, dmem_ready,
    output ifetch_req, ir_load, pc_write, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Jump, Jalr, Branch, ALUOp
  );

  modport slave (
    output Opcode, imem_ready, dmem_ready,
    input  ifetch_req, ir_load, pc_write, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Jump, Jalr, Branch, ALUOp
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequential RV32I main controller: FETCH/DECODE/EXEC/MEM/WB with memory-ready waits and traps.
// Optional performance counters are built when PERF_COUNTERS_EN is defined.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [6:0]  HALT_OPCODE = 7'h7F,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus,
  output logic                    halted,
  output logic                    trap,
  output logic [2:0]              state_o,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        instret_count
);

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpImm  = 7'b0010011;
  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpBr   = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;

  localparam int unsigned     TmoW    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalted = 3'd5,
    StTrap   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            retire;
  logic            is_r, is_imm, is_lw, is_sw, is_br, is_jal, is_jalr, legal;
  logic            tmo_hit, dec_en;

  assign is_r    = (opcode_q == OpR);
  assign is_imm  = (opcode_q == OpImm);
  assign is_lw   = (opcode_q == OpLw);
  assign is_sw   = (opcode_q == OpSw);
  assign is_br   = (opcode_q == OpBr);
  assign is_jal  = (opcode_q == OpJal);
  assign is_jalr = (opcode_q == OpJalr);
  assign legal   = is_r | is_imm | is_lw | is_sw | is_br | is_jal | is_jalr;

  // A timeout of 0 disables the trap; the counter then just wraps harmlessly.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_q == TmoLast);
  assign dec_en  = (state_q inside {StDecode, StExec, StMem, StWb});

  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    tmo_d          = '0;
    retire         = 1'b0;
    bus.ifetch_req = 1'b0;
    bus.ir_load    = 1'b0;
    bus.pc_write   = 1'b0;
    bus.ALUSrc     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.Jump       = 1'b0;
    bus.Jalr       = 1'b0;
    bus.Branch     = 1'b0;
    bus.ALUOp      = 2'b00;

    if (dec_en) begin
      bus.ALUSrc   = is_lw | is_sw | is_imm | is_jal | is_jalr;
      bus.MemtoReg = is_lw;
      bus.Jalr     = is_jalr;
      if (is_br) begin
        bus.ALUOp = 2'b01;
      end else if (is_r) begin
        bus.ALUOp = 2'b10;
      end else if (is_imm) begin
        bus.ALUOp = 2'b11;
      end
    end

    unique case (state_q)
      StFetch: begin
        bus.ifetch_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_load  = 1'b1;
          bus.pc_write = 1'b1;
          opcode_d     = bus.Opcode;
          state_d      = StDecode;
        end else if (tmo_hit) begin
          state_d = StTrap;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDecode: begin
        if (legal) begin
          state_d = StExec;
        end else if (opcode_q == HALT_OPCODE) begin
          retire  = 1'b1;
          state_d = StHalted;
        end else begin
          state_d = StTrap;
        end
      end
      StExec: begin
        if (is_br) begin
          bus.Branch   = 1'b1;
          bus.pc_write = 1'b1;
          retire       = 1'b1;
          state_d      = StFetch;
        end else if (is_jal || is_jalr) begin
          bus.Jump     = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = StWb;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        bus.MemRead  = is_lw;
        bus.MemWrite = is_sw;
        if (bus.dmem_ready) begin
          if (is_lw) begin
            state_d = StWb;
          end else begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end else if (tmo_hit) begin
          state_d = StTrap;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWb: begin
        bus.RegWrite = 1'b1;
        retire       = 1'b1;
        state_d      = StFetch;
      end
      StHalted, StTrap: begin
        state_d = state_q;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    // Reset forces FETCH; keep its strobes quiet while reset is still held.
    if (!reset) begin
      bus.ifetch_req = 1'b0;
      bus.ir_load    = 1'b0;
      bus.pc_write   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StFetch;
      opcode_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      tmo_q    <= tmo_d;
    end
  end

  assign halted  = (state_q == StHalted);
  assign trap    = (state_q == StTrap);
  assign state_o = state_q;

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;

  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (!(state_q inside {StHalted, StTrap})) begin
      cyc_d = cyc_q + CNT_W'(1);
    end
    if (retire) begin
      ret_d = ret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cycle_count   = cyc_q;
  assign instret_count = ret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction expected traces are built from the
// instruction-level rules, queued, and compared cycle by cycle by an independent monitor.
module tb_multicycle_controller;
  localparam int unsigned TMO  = 4;
  localparam int unsigned CW   = 12;
  localparam logic [6:0]  HALT = 7'h7F;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpImm  = 7'b0010011;
  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpBr   = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, SH = 3'd5,
                         ST = 3'd6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  logic          halted, trap;
  logic [2:0]    state_o;
  logic [CW-1:0] cycle_count, instret_count;

  multicycle_controller #(
    .MEM_TIMEOUT(TMO),
    .HALT_OPCODE(HALT),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .halted       (halted),
    .trap         (trap),
    .state_o      (state_o),
    .cycle_count  (cycle_count),
    .instret_count(instret_count)
  );

  logic [14:0] dut_ctl;
  assign dut_ctl = {bus.ifetch_req, bus.ir_load, bus.pc_write, bus.ALUSrc, bus.MemtoReg,
                    bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Jump, bus.Jalr, bus.Branch,
                    bus.ALUOp, halted, trap};

  typedef struct packed {
    logic [2:0]    st;
    logic [14:0]   ctl;
    logic [CW-1:0] cyc;
    logic [CW-1:0] ret;
  } exp_t;

  typedef struct packed {
    logic       im;
    logic       dm;
    logic [6:0] op;
  } stim_t;

  exp_t  sb_q[$];
  exp_t  pend_e[$];
  stim_t pend_s[$];
  int    checks = 0;
  int    errors = 0;
  int    m_cyc  = 0;
  int    m_ret  = 0;

  // Expected control word; decoded levels follow the instruction class when dec is set.
  function automatic logic [14:0] mk(input logic [6:0] op, input bit dec, input bit ifr,
                                     input bit irl, input bit pcw, input bit rw, input bit mr,
                                     input bit mw, input bit jmp, input bit brn, input bit hlt,
                                     input bit trp);
    logic       src, m2r, jr;
    logic [1:0] aop;
    src = dec && (op inside {OpLw, OpSw, OpImm, OpJal, OpJalr});
    m2r = dec && (op == OpLw);
    jr  = dec && (op == OpJalr);
    aop = 2'b00;
    if (dec && op == OpBr)  aop = 2'b01;
    if (dec && op == OpR)   aop = 2'b10;
    if (dec && op == OpImm) aop = 2'b11;
    return {ifr, irl, pcw, src, m2r, rw, mr, mw, jmp, jr, brn, aop, hlt, trp};
  endfunction

  function automatic void step(input logic [2:0] st, input logic [14:0] c, input bit ret_now,
                               input logic im, input logic dm, input logic [6:0] op);
    exp_t  e;
    stim_t s;
    e.st  = st;
    e.ctl = c;
`ifdef PERF_COUNTERS_EN
    e.cyc = CW'(m_cyc);
    e.ret = CW'(m_ret);
`else
    e.cyc = '0;
    e.ret = '0;
`endif
    s.im = im;
    s.dm = dm;
    s.op = op;
    pend_e.push_back(e);
    pend_s.push_back(s);
    if (st != SH && st != ST) m_cyc++;
    if (ret_now) m_ret++;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom);
  endfunction

  // iw/dw: cycles imem/dmem ready stays low; limit truncates the trace (-1 = whole instruction).
  task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input int limit,
                           output bit term);
    bit legal, trapped, halt_f, lw;
    legal   = op inside {OpR, OpImm, OpLw, OpSw, OpBr, OpJal, OpJalr};
    lw      = (op == OpLw);
    trapped = 1'b0;
    halt_f  = 1'b0;
    term    = 1'b0;
    for (int k = 1; k <= iw && !trapped; k++) begin
      step(SF, mk(op, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1'b0, rb(), ro());
      if (k == int'(TMO)) trapped = 1'b1;
    end
    if (!trapped) begin
      step(SF, mk(op, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0, 1'b1, rb(), op);
      step(SD, mk(op, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), !legal && op == HALT, rb(), rb(), ro());
      if (!legal) begin
        if (op == HALT) halt_f = 1'b1;
        else trapped = 1'b1;
      end else if (op == OpBr) begin
        step(SE, mk(op, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0), 1, rb(), rb(), ro());
      end else begin
        if (op == OpJal || op == OpJalr)
          step(SE, mk(op, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0), 0, rb(), rb(), ro());
        else
          step(SE, mk(op, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, rb(), rb(), ro());
        if (op == OpLw || op == OpSw) begin
          for (int k = 1; k <= dw && !trapped; k++) begin
            step(SM, mk(op, 1, 0, 0, 0, 0, lw, !lw, 0, 0, 0, 0), 0, rb(), 1'b0, ro());
            if (k == int'(TMO)) trapped = 1'b1;
          end
          if (!trapped)
            step(SM, mk(op, 1, 0, 0, 0, 0, lw, !lw, 0, 0, 0, 0), !lw, rb(), 1'b1, ro());
        end
        if (!trapped && op != OpSw)
          step(SW, mk(op, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1, rb(), rb(), ro());
      end
    end
    if (trapped || halt_f) begin
      for (int k = 0; k < 3; k++)
        step(trapped ? ST : SH, mk(op, 0, 0, 0, 0, 0, 0, 0, 0, 0, halt_f, trapped), 0, rb(),
             rb(), ro());
      term = 1'b1;
    end
    while (limit >= 0 && pend_e.size() > limit) begin
      void'(pend_e.pop_back());
      void'(pend_s.pop_back());
    end
    foreach (pend_e[i]) sb_q.push_back(pend_e[i]);
    foreach (pend_s[i]) begin
      @(negedge clk);
      bus.imem_ready = pend_s[i].im;
      bus.dmem_ready = pend_s[i].dm;
      bus.Opcode     = pend_s[i].op;
    end
    pend_e.delete();
    pend_s.delete();
  endtask

  task automatic do_reset();
    int n = 0;
    #4;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      #4;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
      sb_q.delete();
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({state_o, dut_ctl, cycle_count, instret_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: state %0d ctl %b cyc %0d ret %0d, required all 0", state_o,
               dut_ctl, cycle_count, instret_count);
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.Opcode     = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    m_cyc = 0;
    m_ret = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({state_o, dut_ctl, cycle_count, instret_count} !== e) begin
          errors++;
          $display("FAIL trace t=%0t: state %0d ctl %b cyc %0d ret %0d, required state %0d ctl %b cyc %0d ret %0d",
                   $time, state_o, dut_ctl, cycle_count, instret_count, e.st, e.ctl, e.cyc,
                   e.ret);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : stimulus
    bit         term;
    logic [6:0] ops[7];
    logic [6:0] op;
    int         r, iw, dw;
    ops = '{OpR, OpImm, OpLw, OpSw, OpBr, OpJal, OpJalr};
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.Opcode     = '0;
    do_reset();

    run_instr(OpR, 0, 0, -1, term);
    run_instr(OpLw, 0, 3, -1, term);
    run_instr(OpBr, 1, 0, -1, term);
    run_instr(OpSw, 2, 1, -1, term);
    run_instr(OpImm, 0, 0, -1, term);
    run_instr(OpJal, 0, 0, -1, term);
    run_instr(OpJalr, 1, 0, -1, term);
    run_instr(OpR, TMO - 1, 0, -1, term);
    run_instr(OpSw, 0, TMO - 1, -1, term);
    run_instr(7'b0000000, 0, 0, -1, term);
    do_reset();
    run_instr(OpR, 0, 0, -1, term);
    run_instr(OpR, TMO, 0, -1, term);
    do_reset();
    run_instr(OpLw, 0, TMO, -1, term);
    do_reset();
    run_instr(OpImm, 0, 0, -1, term);
    run_instr(HALT, 0, 0, -1, term);
    do_reset();

    // Abort a store while it waits in MEM.
    run_instr(OpSw, 0, 6, 5, term);
    #4;
    checks++;
    if (!(bus.MemWrite === 1'b1 && state_o == SM)) begin
      errors++;
      $display("FAIL sw_mem_prereset: MemWrite %b state %0d, required 1 and 3", bus.MemWrite,
               state_o);
    end
    do_reset();
    run_instr(OpR, 0, 0, -1, term);

    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) op = HALT;
      else if (r == 1) op = ro();
      else op = ops[r % 7];
      iw = ($urandom_range(0, 9) == 0) ? int'(TMO) : int'($urandom_range(0, TMO - 1));
      dw = ($urandom_range(0, 9) == 0) ? int'(TMO) : int'($urandom_range(0, TMO - 1));
      run_instr(op, iw, dw, -1, term);
      if (term) do_reset();
    end
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
